// File: rtl/axi_rom_streamer_if.sv
// ---------------------------------------------------------------------------
// axi_rom_streamer_if
// Bundles the AXI4-Lite read channels (AR, R) and the AXI4-Stream output
// of axi_rom_streamer.
//
// Handshake rule for every channel in this bundle: a transfer happens on a
// rising clock edge where valid && ready are both high. Once the source
// raises valid, it holds valid and its payload stable until that edge.
// valid never waits on ready; ready may depend on valid.
//
// Modports:
//   master : the streamer side (drives AR, R ready, stream payload/valid)
//   slave  : the ROM/sink side (drives AR ready, R payload/valid, stream ready)
// ---------------------------------------------------------------------------
interface axi_rom_streamer_if #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4
);
  logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr;
  logic [2:0]                m_axi_arprot;
  logic                      m_axi_arvalid;
  logic                      m_axi_arready;
  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]                m_axi_rresp;
  logic                      m_axi_rvalid;
  logic                      m_axi_rready;
  logic [AXI_DATA_WIDTH-1:0] m_axis_tdata;
  logic                      m_axis_tvalid;
  logic                      m_axis_tready;
  logic                      m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/axi_rom_streamer.sv
// ---------------------------------------------------------------------------
// axi_rom_streamer
// AXI4-Lite read master that fetches len_i consecutive words starting at
// base_addr_i, one read outstanding at a time, and emits them on an
// AXI4-Stream through a single-beat output register.
//
// Ports:
//   axi_clk      clock (rising edge)
//   axi_s_rst    synchronous active-high reset
//   start_i      start request, honoured only in IDLE
//   base_addr_i  first word address, captured on start
//   len_i        word count, captured on start (0 = empty run)
//   busy_o       run in progress
//   done_o       one-cycle pulse after the run finishes
//   err_o        sticky: some rresp was non-OKAY; cleared by next start
//   state_o      FSM state for debug/checkers (0 IDLE,1 ADDR,2 DATA,3 DRAIN)
//   bus          AR/R read channels and the output stream (master modport)
// ---------------------------------------------------------------------------
module axi_rom_streamer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int ADDR_STEP      = AXI_DATA_WIDTH / 8,
  parameter int LEN_WIDTH      = 16
) (
  input  logic                      axi_clk,
  input  logic                      axi_s_rst,
  input  logic                      start_i,
  input  logic [AXI_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [1:0]                state_o,
  axi_rom_streamer_if.master        bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [AXI_ADDR_WIDTH-1:0] STEP = AXI_ADDR_WIDTH'(ADDR_STEP);
  localparam logic [LEN_WIDTH-1:0]      ONE  = LEN_WIDTH'(1);

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      rem_q, rem_d;
  logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      tlast_q, tlast_d;
  logic                      err_q, err_d;
  logic                      done_q, done_d;

  logic rready_c;
  logic r_fire;
  logic s_fire;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    err_d    = err_q;
    done_d   = 1'b0;

    s_fire   = tvalid_q && bus.m_axis_tready;
    // Only accept read data when the output register is free or being
    // emptied this cycle, so a stalled sink holds the slave's R channel.
    rready_c = (state_q == ST_DATA) && (!tvalid_q || bus.m_axis_tready);
    r_fire   = rready_c && bus.m_axi_rvalid;

    // Accepted beat leaves the register unless refilled below.
    if (s_fire) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          addr_d = base_addr_i;
          rem_d  = len_i;
          err_d  = 1'b0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end
      ST_ADDR: begin
        if (bus.m_axi_arready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_fire) begin
          tdata_d  = bus.m_axi_rdata;
          tvalid_d = 1'b1;
          tlast_d  = (rem_q == ONE);
          if (bus.m_axi_rresp != 2'b00) begin
            err_d = 1'b1;
          end
          rem_d   = rem_q - ONE;
          addr_d  = addr_q + STEP;
          state_d = (rem_q > ONE) ? ST_ADDR : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (s_fire && tlast_q) begin
          done_d   = 1'b1;
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_s_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      rem_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign state_o = state_q;

  assign bus.m_axi_araddr  = addr_q;
  assign bus.m_axi_arprot  = 3'b000;
  assign bus.m_axi_arvalid = (state_q == ST_ADDR);
  assign bus.m_axi_rready  = rready_c;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;

endmodule
